// File: rtl/dl_demux_pkg.sv
// Shared types for the stream demultiplexer: skid-buffer state encoding and
// occupancy width.
package dl_demux_pkg;

  localparam int OCC_WIDTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [OCC_WIDTH-1:0] occ_of(input state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dl_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered ready.
//   state | meaning
//   EMPTY | nothing held; main and skid free
//   ONE   | head word in main; skid free
//   TWO   | main and skid both hold words; input stalled
module dl_skid_buf
  import dl_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_payload,
  output logic [OCC_WIDTH-1:0] occupancy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q;
  logic             in_fire, out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != TWO);
    end
  end

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = in_valid && ready_q;
    out_fire = (state_q != EMPTY) && out_ready;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_payload;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_payload;
        end else if (in_fire) begin
          skid_d  = in_payload;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // skid is promoted in the same cycle the head leaves
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign in_ready    = ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_payload = main_q;
  assign occupancy   = occ_of(state_q);

endmodule

// File: rtl/dl_demux32_stream.sv
// Registered 1-to-N stream demultiplexer: a skid-buffered {sel, data} stream
// steered to one of NUM_OUTPUTS valid/ready destinations in strict FIFO order.
module dl_demux32_stream
  import dl_demux_pkg::*;
#(
  parameter int NUM_BITS    = 32,
  parameter int NUM_OUTPUTS = 32,
  parameter int SEL_WIDTH   = $clog2(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_BITS-1:0]    in_data,
  input  logic [SEL_WIDTH-1:0]   in_sel,
  output logic [NUM_OUTPUTS-1:0] out_valid,
  input  logic [NUM_OUTPUTS-1:0] out_ready,
  output logic [NUM_BITS-1:0]    out_data,
  output logic [OCC_WIDTH-1:0]   occupancy,
  output logic                   err_drop
);

  localparam int PAY_W = SEL_WIDTH + NUM_BITS;
  localparam int PAD_W = 1 << SEL_WIDTH;

  logic                 in_range;
  logic                 buf_in_valid;
  logic                 head_valid;
  logic                 head_ready;
  logic [PAY_W-1:0]     head_payload;
  logic [SEL_WIDTH-1:0] head_sel;
  logic [PAD_W-1:0]     ready_pad;
  logic                 err_q;

  assign in_range     = ({1'b0, in_sel} < (SEL_WIDTH + 1)'(NUM_OUTPUTS));
  // out-of-range words are still handshaken so the source never stalls on them
  assign buf_in_valid = in_valid && in_range;

  dl_skid_buf #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (buf_in_valid),
    .in_ready    (in_ready),
    .in_payload  ({in_sel, in_data}),
    .out_valid   (head_valid),
    .out_ready   (head_ready),
    .out_payload (head_payload),
    .occupancy   (occupancy)
  );

  assign head_sel   = head_payload[NUM_BITS +: SEL_WIDTH];
  assign out_data   = head_payload[NUM_BITS-1:0];
  assign ready_pad  = PAD_W'(out_ready);
  assign head_ready = ready_pad[head_sel];

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      out_valid[i] = head_valid && (head_sel == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= in_valid && in_ready && !in_range;
    end
  end

  assign err_drop = err_q;

endmodule

// File: tb/tb_dl_demux32_stream.sv
// Directed bench: a 32-way instance checked through a FIFO scoreboard and a
// 20-way instance for out-of-range index handling.
module tb_dl_demux32_stream;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic [4:0]  a_in_sel;
  logic [31:0] a_out_valid, a_out_ready, a_out_data;
  logic [1:0]  a_occ;
  logic        a_err;

  logic        b_in_valid, b_in_ready;
  logic [31:0] b_in_data;
  logic [4:0]  b_in_sel;
  logic [19:0] b_out_valid, b_out_ready;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic        b_err;

  item_t sb[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    n_deliv = 0;

  always #5 clk = ~clk;

  dl_demux32_stream u_a (
    .clk (clk), .rst_n (rst_n),
    .in_valid (a_in_valid), .in_ready (a_in_ready),
    .in_data (a_in_data), .in_sel (a_in_sel),
    .out_valid (a_out_valid), .out_ready (a_out_ready),
    .out_data (a_out_data), .occupancy (a_occ), .err_drop (a_err)
  );

  dl_demux32_stream #(.NUM_BITS (32), .NUM_OUTPUTS (20)) u_b (
    .clk (clk), .rst_n (rst_n),
    .in_valid (b_in_valid), .in_ready (b_in_ready),
    .in_data (b_in_data), .in_sel (b_in_sel),
    .out_valid (b_out_valid), .out_ready (b_out_ready),
    .out_data (b_out_data), .occupancy (b_occ), .err_drop (b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: inputs and outputs are stable between negedge and the next posedge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((a_out_valid & a_out_ready) != '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_delivery", 32'(sb.size()), 32'd1);
        end else begin
          item_t e;
          e = sb.pop_front();
          chk("sb_out_valid", a_out_valid, 32'd1 << e.sel);
          chk("sb_out_data", a_out_data, e.data);
          n_deliv++;
        end
      end
      if (a_in_valid === 1'b1 && a_in_ready === 1'b1) begin
        sb.push_back('{sel: a_in_sel, data: a_in_data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = '1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = '1;

    // reset values
    repeat (3) @(posedge clk);
    #3;
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_valid", a_out_valid, 32'd0);
    chk("rst_out_data", a_out_data, 32'd0);
    chk("rst_occ", 32'(a_occ), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", 32'(a_in_ready), 32'd0);
    step();
    chk("rel_in_ready_high", 32'(a_in_ready), 32'd1);
    chk("rel_b_in_ready", 32'(b_in_ready), 32'd1);

    // single word
    a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF; a_in_sel = 5'd5;
    step();
    a_in_valid = 1'b0;
    chk("single_out_valid", a_out_valid, 32'h0000_0020);
    chk("single_out_data", a_out_data, 32'hDEADBEEF);
    chk("single_occ", 32'(a_occ), 32'd1);
    step();
    chk("single_occ_after", 32'(a_occ), 32'd0);
    chk("single_empty_valid", a_out_valid, 32'd0);
    chk("single_data_retained", a_out_data, 32'hDEADBEEF);

    // back-to-back stream, one delivery per cycle
    for (int i = 0; i < 32; i++) begin
      a_in_valid = 1'b1; a_in_sel = 5'(i); a_in_data = 32'(i) * 32'h01010101;
      step();
      chk("b2b_out_valid", a_out_valid, 32'd1 << i);
      chk("b2b_in_ready", 32'(a_in_ready), 32'd1);
      chk("b2b_occ", 32'(a_occ), 32'd1);
    end
    a_in_valid = 1'b0;
    step();
    chk("b2b_deliveries", 32'(n_deliv), 32'd33);

    // backpressure into the skid register
    a_out_ready = ~(32'd1 << 3);
    a_in_valid = 1'b1; a_in_sel = 5'd3; a_in_data = 32'hA3A3_0003;
    step();
    a_in_sel = 5'd7; a_in_data = 32'hA7A7_0007;
    step();
    a_in_valid = 1'b0;
    chk("bp_occ", 32'(a_occ), 32'd2);
    chk("bp_in_ready", 32'(a_in_ready), 32'd0);
    repeat (3) step();
    chk("bp_out_valid_stable", a_out_valid, 32'h0000_0008);
    chk("bp_out_data_stable", a_out_data, 32'hA3A3_0003);
    chk("bp_no_early_delivery", 32'(n_deliv), 32'd33);
    a_out_ready = '1;
    step();
    chk("bp_next_valid", a_out_valid, 32'h0000_0080);
    chk("bp_in_ready_back", 32'(a_in_ready), 32'd1);
    chk("bp_occ_one", 32'(a_occ), 32'd1);
    step();
    chk("bp_drained", 32'(a_occ), 32'd0);

    // ready asserted only on non-selected destinations
    a_out_ready = ~(32'd1 << 10);
    a_in_valid = 1'b1; a_in_sel = 5'd10; a_in_data = 32'h1234_5678;
    step();
    a_in_valid = 1'b0;
    held = a_out_data;
    repeat (20) step();
    chk("wd_out_valid", a_out_valid, 32'h0000_0400);
    chk("wd_out_data", a_out_data, 32'h1234_5678);
    chk("wd_data_unchanged", a_out_data, held);
    chk("wd_no_delivery", 32'(n_deliv), 32'd35);
    a_out_ready = '1;
    step();
    chk("wd_drained", 32'(a_occ), 32'd0);

    // X on in_sel while idle must not disturb state
    a_in_sel = 'x; a_in_data = 'x;
    repeat (3) step();
    chk("xsel_occ", 32'(a_occ), 32'd0);
    chk("xsel_out_valid", a_out_valid, 32'd0);

    // out-of-range index on the 20-way instance
    b_in_valid = 1'b1; b_in_sel = 5'd25; b_in_data = 32'h0BAD_0025;
    step();
    b_in_valid = 1'b0;
    chk("oor_err_pulse", 32'(b_err), 32'd1);
    chk("oor_out_valid", 32'(b_out_valid), 32'd0);
    chk("oor_occ", 32'(b_occ), 32'd0);
    step();
    chk("oor_err_clear", 32'(b_err), 32'd0);
    b_in_valid = 1'b1; b_in_sel = 5'd19; b_in_data = 32'h0000_0019;
    step();
    b_in_valid = 1'b0;
    chk("b_top_valid", 32'(b_out_valid), 32'h0008_0000);
    chk("b_top_data", b_out_data, 32'h0000_0019);
    chk("b_top_no_err", 32'(b_err), 32'd0);

    // asynchronous reset while two words are held
    a_out_ready = ~(32'd1 << 3);
    a_in_valid = 1'b1; a_in_sel = 5'd3; a_in_data = 32'h5555_0003;
    step();
    a_in_sel = 5'd7; a_in_data = 32'h5555_0007;
    step();
    a_in_valid = 1'b0;
    chk("mr_occ_two", 32'(a_occ), 32'd2);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mr_out_valid", a_out_valid, 32'd0);
    chk("mr_in_ready", 32'(a_in_ready), 32'd0);
    chk("mr_occ", 32'(a_occ), 32'd0);
    a_out_ready = '1;
    step();
    #2;
    rst_n = 1'b1;
    step();
    a_in_valid = 1'b1; a_in_sel = 5'd12; a_in_data = 32'h00C0_FFEE;
    step();
    a_in_valid = 1'b0;
    chk("mr_first_valid", a_out_valid, 32'h0000_1000);
    chk("mr_first_data", a_out_data, 32'h00C0_FFEE);

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_deliveries", 32'(n_deliv), 32'd37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
